// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: drives the rPLL RESET pin, qualifies LOCK, then releases
// the system and peripheral reset domains in order. Re-locks the PLL when lock
// is lost or when lock is not acquired within a timeout.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned STAGE_GAP_CYCLES    = 8,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lock_i,
  input  logic       sw_rst_req_i,
  output logic       pll_reset_o,
  output logic       sys_rst_n_o,
  output logic       periph_rst_n_o,
  output logic       ready_o,
  output logic [7:0] relock_cnt_o
);

  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                    PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CD  = (LOCK_TIMEOUT_CYCLES > STAGE_GAP_CYCLES) ?
                                    LOCK_TIMEOUT_CYCLES : STAGE_GAP_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_REL_SYS,
    S_RUN
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   relock_inc_c;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Synchronise the asynchronous PLL lock into the reference clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lock_i};
    end
  end

  // Next-state and shared counter; the counter restarts on every transition.
  // Entering STABLE from WAIT_LOCK preloads 1 because the lock sample that
  // caused the transition already counts towards the stability window.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    relock_inc_c = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          if (LOCK_STABLE_CYCLES == 1) begin
            state_d = S_REL_SYS;
            cnt_d   = '0;
          end else begin
            state_d = S_STABLE;
            cnt_d   = CNT_W'(1);
          end
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          state_d      = S_PLL_RST;
          cnt_d        = '0;
          relock_inc_c = 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = S_REL_SYS;
          cnt_d   = '0;
        end
      end
      S_REL_SYS, S_RUN: begin
        if (!lock_s) begin
          state_d      = S_PLL_RST;
          cnt_d        = '0;
          relock_inc_c = 1'b1;
        end else if (sw_rst_req_i) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (state_q == S_RUN) begin
          cnt_d = cnt_q;
        end else if (cnt_q == CNT_W'(STAGE_GAP_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, relock count and outputs decoded from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_PLL_RST;
      cnt_q          <= '0;
      relock_cnt_o   <= '0;
      pll_reset_o    <= 1'b1;
      sys_rst_n_o    <= 1'b0;
      periph_rst_n_o <= 1'b0;
      ready_o        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      if (relock_inc_c && (relock_cnt_o != 8'hFF)) begin
        relock_cnt_o <= relock_cnt_o + 8'd1;
      end
      pll_reset_o    <= (state_d == S_PLL_RST);
      sys_rst_n_o    <= (state_d == S_REL_SYS) || (state_d == S_RUN);
      periph_rst_n_o <= (state_d == S_RUN);
      ready_o        <= (state_d == S_RUN);
    end
  end

endmodule
